// File: rtl/change_pkg.sv
// Shared types and coin values for the change dispenser.
// Coin encodings are chosen so the code equals the coin value in nickels.
package change_pkg;

  typedef enum logic [2:0] {
    COIN_NONE    = 3'b000,
    COIN_NICKEL  = 3'b001,
    COIN_DIME    = 3'b010,
    COIN_QUARTER = 3'b101
  } coin_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_OFFER  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Coin values in nickels.
  localparam int unsigned VAL_Q = 5;
  localparam int unsigned VAL_D = 2;
  localparam int unsigned VAL_N = 1;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin not exceeding owed with stock on hand.
// Ports:
//   owed                      nickels still owed
//   quarters/dimes/nickels    live inventory counts
//   coin_c                    chosen coin, COIN_NONE if nothing fits
module coin_select
  import change_pkg::*;
#(
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned CNT_W   = 2
) (
  input  logic [PRICE_W-1:0] owed,
  input  logic [CNT_W-1:0]   quarters,
  input  logic [CNT_W-1:0]   dimes,
  input  logic [CNT_W-1:0]   nickels,
  output coin_e              coin_c
);

  // Priority order quarter > dime > nickel; no backtracking.
  always_comb begin
    coin_c = COIN_NONE;
    if (owed >= PRICE_W'(VAL_Q) && quarters != '0) begin
      coin_c = COIN_QUARTER;
    end else if (owed >= PRICE_W'(VAL_D) && dimes != '0) begin
      coin_c = COIN_DIME;
    end else if (owed >= PRICE_W'(VAL_N) && nickels != '0) begin
      coin_c = COIN_NICKEL;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Sequential change dispenser: accepts a purchase, then hands out change one
// coin per handshake from live, refillable per-denomination inventory.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   InValid/InReady, Cost, Paid         purchase request handshake
//   RefillValid, Refill*                inventory refill, accepted any cycle
//   CoinValid/CoinReady, Coin           coin offer handshake to the ejector
//   Done                                one-cycle finish pulse
//   ExactAmount, CoughUpMore,
//   NotEnoughChange, Remaining          status, held until the next request
//   QuartersLeft/DimesLeft/NickelsLeft  live inventory
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned INIT_Q  = 3,
  parameter int unsigned INIT_D  = 3,
  parameter int unsigned INIT_N  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [PRICE_W-1:0] Cost,
  input  logic [PRICE_W-1:0] Paid,
  input  logic               RefillValid,
  input  logic [CNT_W-1:0]   RefillQuarters,
  input  logic [CNT_W-1:0]   RefillDimes,
  input  logic [CNT_W-1:0]   RefillNickels,
  output logic               CoinValid,
  input  logic               CoinReady,
  output logic [2:0]         Coin,
  output logic               Done,
  output logic               ExactAmount,
  output logic               CoughUpMore,
  output logic               NotEnoughChange,
  output logic [PRICE_W-1:0] Remaining,
  output logic [CNT_W-1:0]   QuartersLeft,
  output logic [CNT_W-1:0]   DimesLeft,
  output logic [CNT_W-1:0]   NickelsLeft
);

  localparam int unsigned      SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [PRICE_W-1:0] owed_q, owed_d;
  coin_e              coin_q, coin_d;
  coin_e              sel_coin_c;
  logic               exact_d, short_d, nec_d;
  logic [PRICE_W-1:0] rem_d;
  logic               deb_q, deb_d, deb_n;
  logic [CNT_W-1:0]   q_d, d_d, n_d;
  logic [PRICE_W:0]   cost_x_c, paid_x_c;
  logic [PRICE_W-1:0] owed_sub_c;

  // Extra bit so an unsigned compare cannot wrap.
  assign cost_x_c   = {1'b0, Cost};
  assign paid_x_c   = {1'b0, Paid};
  assign owed_sub_c = owed_q - PRICE_W'(coin_q);
  assign Coin       = coin_q;

  coin_select #(
    .PRICE_W (PRICE_W),
    .CNT_W   (CNT_W)
  ) u_coin_select (
    .owed     (owed_q),
    .quarters (QuartersLeft),
    .dimes    (DimesLeft),
    .nickels  (NickelsLeft),
    .coin_c   (sel_coin_c)
  );

  // count - debit + refill, saturating at the counter maximum.
  function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                input logic             dec,
                                                input logic [CNT_W-1:0] add);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(add) - SUM_W'(dec);
    return (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Next-state, datapath and inventory update.
  always_comb begin
    state_d = state_q;
    owed_d  = owed_q;
    coin_d  = coin_q;
    exact_d = ExactAmount;
    short_d = CoughUpMore;
    nec_d   = NotEnoughChange;
    rem_d   = Remaining;
    deb_q   = 1'b0;
    deb_d   = 1'b0;
    deb_n   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          exact_d = 1'b0;
          short_d = 1'b0;
          nec_d   = 1'b0;
          rem_d   = '0;
          if (paid_x_c < cost_x_c) begin
            short_d = 1'b1;
            state_d = S_DONE;
          end else if (paid_x_c == cost_x_c) begin
            exact_d = 1'b1;
            state_d = S_DONE;
          end else begin
            owed_d  = Paid - Cost;
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (sel_coin_c != COIN_NONE) begin
          coin_d  = sel_coin_c;
          state_d = S_OFFER;
        end else begin
          nec_d   = 1'b1;
          rem_d   = owed_q;
          state_d = S_DONE;
        end
      end
      S_OFFER: begin
        // Coin stays latched until taken, regardless of refills.
        if (CoinReady) begin
          case (coin_q)
            COIN_QUARTER: deb_q = 1'b1;
            COIN_DIME:    deb_d = 1'b1;
            COIN_NICKEL:  deb_n = 1'b1;
            default:      ;
          endcase
          owed_d = owed_sub_c;
          coin_d = COIN_NONE;
          if (owed_sub_c == '0) begin
            nec_d   = 1'b0;
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    q_d = inv_next(QuartersLeft, deb_q, RefillValid ? RefillQuarters : '0);
    d_d = inv_next(DimesLeft,    deb_d, RefillValid ? RefillDimes    : '0);
    n_d = inv_next(NickelsLeft,  deb_n, RefillValid ? RefillNickels  : '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      owed_q          <= '0;
      coin_q          <= COIN_NONE;
      InReady         <= 1'b1;
      CoinValid       <= 1'b0;
      Done            <= 1'b0;
      ExactAmount     <= 1'b0;
      CoughUpMore     <= 1'b0;
      NotEnoughChange <= 1'b0;
      Remaining       <= '0;
      QuartersLeft    <= CNT_W'(INIT_Q);
      DimesLeft       <= CNT_W'(INIT_D);
      NickelsLeft     <= CNT_W'(INIT_N);
    end else begin
      state_q         <= state_d;
      owed_q          <= owed_d;
      coin_q          <= coin_d;
      InReady         <= (state_d == S_IDLE);
      CoinValid       <= (state_d == S_OFFER);
      Done            <= (state_d == S_DONE);
      ExactAmount     <= exact_d;
      CoughUpMore     <= short_d;
      NotEnoughChange <= nec_d;
      Remaining       <= rem_d;
      QuartersLeft    <= q_d;
      DimesLeft       <= d_d;
      NickelsLeft     <= n_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed table, hand-written corner sequences,
// then random purchases with random stalls and refills against a greedy
// change model and a per-cycle inventory model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       InValid, InValid2;
  logic [3:0] Cost, Paid;
  logic       RefillValid;
  logic [1:0] RefillQuarters, RefillDimes, RefillNickels;
  logic       CoinReady;

  logic       InReady, CoinValid, Done, ExactAmount, CoughUpMore, NotEnoughChange;
  logic [2:0] Coin;
  logic [3:0] Remaining;
  logic [1:0] QuartersLeft, DimesLeft, NickelsLeft;

  logic       InReady2, CoinValid2, Done2, ExactAmount2, CoughUpMore2, NotEnoughChange2;
  logic [2:0] Coin2;
  logic [3:0] Remaining2;
  logic [1:0] QuartersLeft2, DimesLeft2, NickelsLeft2;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .Cost(Cost), .Paid(Paid), .RefillValid(RefillValid),
    .RefillQuarters(RefillQuarters), .RefillDimes(RefillDimes), .RefillNickels(RefillNickels),
    .CoinValid(CoinValid), .CoinReady(CoinReady), .Coin(Coin), .Done(Done),
    .ExactAmount(ExactAmount), .CoughUpMore(CoughUpMore), .NotEnoughChange(NotEnoughChange),
    .Remaining(Remaining), .QuartersLeft(QuartersLeft), .DimesLeft(DimesLeft),
    .NickelsLeft(NickelsLeft)
  );

  change_dispenser #(.INIT_Q(1), .INIT_D(3), .INIT_N(0)) dut2 (
    .clk(clk), .reset(reset), .InValid(InValid2), .InReady(InReady2),
    .Cost(Cost), .Paid(Paid), .RefillValid(RefillValid),
    .RefillQuarters(RefillQuarters), .RefillDimes(RefillDimes), .RefillNickels(RefillNickels),
    .CoinValid(CoinValid2), .CoinReady(CoinReady), .Coin(Coin2), .Done(Done2),
    .ExactAmount(ExactAmount2), .CoughUpMore(CoughUpMore2), .NotEnoughChange(NotEnoughChange2),
    .Remaining(Remaining2), .QuartersLeft(QuartersLeft2), .DimesLeft(DimesLeft2),
    .NickelsLeft(NickelsLeft2)
  );

  localparam int CMAX = 3;

  int nvec = 0;
  int nerr = 0;
  int inv[3];                       // model inventory: quarter, dime, nickel
  int val[3]  = '{5, 2, 1};         // value in nickels
  int code[3] = '{5, 2, 1};         // expected Coin encoding
  bit rr_mode = 1'b0;               // randomize refill inputs each cycle

  typedef struct {
    int cost; int paid; int ex; int sh; int nec; int rem; int ncoins;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int owed);
    for (int k = 0; k < 3; k++)
      if (inv[k] > 0 && val[k] <= owed) return k;
    return -1;
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // One clock: model inventory follows the edge, then check at the negedge.
  task automatic tick(input bit debit, input int idx);
    int r[3];
    @(posedge clk);
    r[0] = RefillValid ? int'(RefillQuarters) : 0;
    r[1] = RefillValid ? int'(RefillDimes)    : 0;
    r[2] = RefillValid ? int'(RefillNickels)  : 0;
    for (int k = 0; k < 3; k++) begin
      if (reset) inv[k] = 3;
      else inv[k] = sat(inv[k] - ((debit && idx == k) ? 1 : 0) + r[k]);
    end
    @(negedge clk);
    chk("inv_q", int'(QuartersLeft), inv[0]);
    chk("inv_d", int'(DimesLeft),    inv[1]);
    chk("inv_n", int'(NickelsLeft),  inv[2]);
    if (rr_mode) begin
      RefillValid    = ($urandom_range(0, 3) == 0);
      RefillQuarters = 2'($urandom_range(0, 3));
      RefillDimes    = 2'($urandom_range(0, 3));
      RefillNickels  = 2'($urandom_range(0, 3));
    end
  endtask

  // Full purchase on dut, checked against greedy model and fixed latencies.
  task automatic txn(input int cost, input int paid, input int stall_max, output int ncoins);
    int owed, idx, stalls, guard;
    bit rdy;
    ncoins = 0;
    owed   = 0;
    chk("accept_inready", int'(InReady), 1);
    InValid = 1'b1; Cost = 4'(cost); Paid = 4'(paid);
    tick(0, 0);
    InValid = 1'b0;
    if (paid > cost) begin
      owed  = paid - cost;
      guard = 0;
      while (guard < 20) begin
        guard++;
        chk("select_coinvalid", int'(CoinValid), 0);
        chk("select_coin",      int'(Coin), 0);
        chk("select_inready",   int'(InReady), 0);
        idx = pick(owed);
        tick(0, 0);
        if (idx < 0) break;
        stalls = 0;
        while (1) begin
          chk("offer_coinvalid", int'(CoinValid), 1);
          chk("offer_coin",      int'(Coin), code[idx]);
          chk("offer_done",      int'(Done), 0);
          rdy = (stalls >= stall_max) || ($urandom_range(0, 1) == 1);
          CoinReady = rdy;
          tick(rdy, idx);
          CoinReady = 1'b0;
          if (rdy) break;
          stalls++;
        end
        ncoins++;
        owed -= val[idx];
        if (owed == 0) break;
      end
    end
    chk("done_pulse",     int'(Done), 1);
    chk("done_coinvalid", int'(CoinValid), 0);
    chk("done_inready",   int'(InReady), 0);
    chk("done_exact",     int'(ExactAmount), (paid == cost) ? 1 : 0);
    chk("done_short",     int'(CoughUpMore), (paid < cost) ? 1 : 0);
    chk("done_nec",       int'(NotEnoughChange), (owed > 0) ? 1 : 0);
    chk("done_remaining", int'(Remaining), owed);
    tick(0, 0);
    chk("after_done",     int'(Done), 0);
    chk("after_inready",  int'(InReady), 1);
    chk("hold_remaining", int'(Remaining), owed);
  endtask

  initial begin
    int nc;
    reset = 1'b1; InValid = 1'b0; InValid2 = 1'b0; Cost = '0; Paid = '0;
    RefillValid = 1'b0; RefillQuarters = '0; RefillDimes = '0; RefillNickels = '0;
    CoinReady = 1'b0;
    inv = '{3, 3, 3};
    @(negedge clk);
    tick(0, 0);
    reset = 1'b0;
    chk("rst_inready",   int'(InReady), 1);
    chk("rst_coinvalid", int'(CoinValid), 0);
    chk("rst_coin",      int'(Coin), 0);
    chk("rst_done",      int'(Done), 0);
    chk("rst_status",    int'({ExactAmount, CoughUpMore, NotEnoughChange}), 0);
    chk("rst_remaining", int'(Remaining), 0);
    chk("rst_q", int'(QuartersLeft), 3);

    // Alternate inventory 1/3/0: owed 6 takes a quarter, then is stuck at 1.
    InValid2 = 1'b1; Cost = 4'd0; Paid = 4'd6;
    tick(0, 0);
    InValid2 = 1'b0;
    chk("d2_sel_coinvalid", int'(CoinValid2), 0);
    tick(0, 0);
    chk("d2_offer_valid", int'(CoinValid2), 1);
    chk("d2_offer_coin",  int'(Coin2), 5);
    CoinReady = 1'b1;
    tick(0, 0);
    CoinReady = 1'b0;
    chk("d2_q_after", int'(QuartersLeft2), 0);
    chk("d2_sel2_coinvalid", int'(CoinValid2), 0);
    tick(0, 0);
    chk("d2_done", int'(Done2), 1);
    chk("d2_nec",  int'(NotEnoughChange2), 1);
    chk("d2_rem",  int'(Remaining2), 1);
    chk("d2_d",    int'(DimesLeft2), 3);
    tick(0, 0);

    // Directed table starting from 3/3/3.
    tbl[0] = '{cost:4, paid:4,  ex:1, sh:0, nec:0, rem:0, ncoins:0};
    tbl[1] = '{cost:5, paid:3,  ex:0, sh:1, nec:0, rem:0, ncoins:0};
    tbl[2] = '{cost:1, paid:9,  ex:0, sh:0, nec:0, rem:0, ncoins:3};
    tbl[3] = '{cost:0, paid:15, ex:0, sh:0, nec:0, rem:0, ncoins:5};
    tbl[4] = '{cost:0, paid:4,  ex:0, sh:0, nec:1, rem:3, ncoins:1};
    for (int i = 0; i < 5; i++) begin
      txn(tbl[i].cost, tbl[i].paid, 0, nc);
      chk("tbl_exact", int'(ExactAmount),     tbl[i].ex);
      chk("tbl_short", int'(CoughUpMore),     tbl[i].sh);
      chk("tbl_nec",   int'(NotEnoughChange), tbl[i].nec);
      chk("tbl_rem",   int'(Remaining),       tbl[i].rem);
      chk("tbl_coins", nc,                    tbl[i].ncoins);
    end
    chk("tbl_end_inv", int'({QuartersLeft, DimesLeft, NickelsLeft}), 0);

    // Refill to full, then reset while a dime is on offer.
    RefillValid = 1'b1; RefillQuarters = 2'd3; RefillDimes = 2'd3; RefillNickels = 2'd3;
    tick(0, 0);
    RefillValid = 1'b0;
    InValid = 1'b1; Cost = 4'd1; Paid = 4'd9;
    tick(0, 0);
    InValid = 1'b0;
    tick(0, 0);
    chk("rip_coin_q", int'(Coin), 5);
    CoinReady = 1'b1;
    tick(1, 0);
    CoinReady = 1'b0;
    tick(0, 0);
    chk("rip_coin_d", int'(Coin), 2);
    chk("rip_q_debited", int'(QuartersLeft), 2);
    reset = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    chk("rip_inready",   int'(InReady), 1);
    chk("rip_coinvalid", int'(CoinValid), 0);
    chk("rip_coin",      int'(Coin), 0);
    chk("rip_done",      int'(Done), 0);
    chk("rip_status",    int'({ExactAmount, CoughUpMore, NotEnoughChange}), 0);
    chk("rip_remaining", int'(Remaining), 0);
    chk("rip_inv", int'({QuartersLeft, DimesLeft, NickelsLeft}), 6'b111111);

    // Stall 3 cycles with quarter refills: coin held, count saturates.
    InValid = 1'b1; Cost = 4'd0; Paid = 4'd5;
    tick(0, 0);
    InValid = 1'b0;
    tick(0, 0);
    RefillValid = 1'b1; RefillQuarters = 2'd2; RefillDimes = 2'd0; RefillNickels = 2'd0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid",   int'(CoinValid), 1);
      chk("stall_coin",    int'(Coin), 5);
      chk("stall_inready", int'(InReady), 0);
      CoinReady = (i == 3);
      tick(i == 3, 0);
    end
    CoinReady = 1'b0; RefillValid = 1'b0;
    chk("stall_q_sat", int'(QuartersLeft), 3);
    chk("stall_done",  int'(Done), 1);
    chk("stall_inready_done", int'(InReady), 0);
    chk("stall_nec",   int'(NotEnoughChange), 0);
    tick(0, 0);
    chk("stall_inready_after", int'(InReady), 1);

    // Random purchases with random stalls and refills.
    rr_mode = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int c, p, idle;
      c = $urandom_range(0, 15);
      p = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 15 - $urandom_range(0, 3);
      txn(c, p, $urandom_range(0, 3), nc);
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) tick(0, 0);
    end
    rr_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequential successor to the combinational change box. It accepts one purchase per handshake and computes the change owed. It then dispenses that change one coin per handshake, largest coin first, from live per-denomination inventory counters that decrement on each dispense and accept refills. It sits between the payment front end and the coin-ejector mechanism.

Parameters:
PRICE_W, 4, width of Cost/Paid/Remaining in nickels (max 2^PRICE_W-1 nickels)
CNT_W, 2, width of each coin inventory counter
INIT_Q, 3, quarter count loaded at reset
INIT_D, 3, dime count loaded at reset
INIT_N, 3, nickel count loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
InValid  in  1  purchase request valid
InReady  out  1  block idle, can accept a request
Cost  in  PRICE_W  item cost in nickels, unsigned
Paid  in  PRICE_W  amount paid in nickels, unsigned
RefillValid  in  1  add refill amounts to inventory this cycle
RefillQuarters / RefillDimes / RefillNickels  in  CNT_W each  coins added
CoinValid  out  1  coin offered to ejector
CoinReady  in  1  ejector takes the coin
Coin  out  3  offered coin value: 3'b101 quarter, 3'b010 dime, 3'b001 nickel, 3'b000 none
Done  out  1  one-cycle pulse, transaction finished; status valid
ExactAmount  out  1  status: Paid == Cost
CoughUpMore  out  1  status: Paid < Cost
NotEnoughChange  out  1  status: change owed could not be completed
Remaining  out  PRICE_W  status: nickels still owed at finish
QuartersLeft / DimesLeft / NickelsLeft  out  CNT_W each  live inventory

Behaviour:
- Reset: state IDLE; counters reload to INIT_*. CoinValid=0, Coin=0, Done=0, all status outputs=0. Reset mid-transaction abandons it; a coin offered but not handshaken is not debited.
- States: IDLE, SELECT, OFFER, DONE.
- IDLE: InReady=1 (0 in every other state). On InValid&&InReady, latch Cost/Paid and compare at PRICE_W+1 bits. Clear all status outputs.
  - Paid<Cost: go to DONE with CoughUpMore=1, Remaining=0.
  - Paid==Cost: go to DONE with ExactAmount=1.
  - Otherwise: owed=Paid-Cost; go to SELECT.
- SELECT: pick the largest coin with value<=owed and count>0, checking quarter, then dime, then nickel.
  - Coin found: register it into Coin, go to OFFER.
  - No coin found: go to DONE with NotEnoughChange=1, Remaining=owed.
  - Selection is strictly greedy, with no backtracking. Example: owed 6, Q=1, N=0 gives a quarter, then fails.
- OFFER: CoinValid=1. Coin is held stable until CoinReady, even if a refill changes inventory.
  - On CoinReady: debit that counter by 1; owed -= Coin value.
  - New owed==0: go to DONE, NotEnoughChange=0, Remaining=0. Otherwise go back to SELECT.
- DONE: Done=1 for exactly one cycle, then go to IDLE. Status outputs hold until the next request is accepted.
- Latency: accept at cycle t gives Done at t+1 for exact/short pay. First CoinValid is at t+2. Each further coin costs 2 cycles plus stall cycles.
- Inventory: each cycle, next = count - debit + (RefillValid ? refill : 0), saturating at 2^CNT_W-1. A simultaneous debit and refill of the same coin nets both. Refill is accepted in every state.
- Coin is 0 whenever CoinValid=0.

Decomposition:
- Package change_pkg holds:
  - coin_e enum: COIN_NONE=3'b000, COIN_NICKEL=3'b001, COIN_DIME=3'b010, COIN_QUARTER=3'b101.
  - state_e enum.
  - Constant VAL_Q=5, VAL_D=2, VAL_N=1.
- One sub-module, coin_select: purely combinational, takes owed and the three counts, outputs coin_e.

Test Plan:
- Cost=4, Paid=4 (defaults): Done at t+1; ExactAmount=1, NotEnoughChange=0; no CoinValid; counts stay 3/3/3.
- Cost=5, Paid=3: Done at t+1; CoughUpMore=1, Remaining=0; counts unchanged.
- Cost=1, Paid=9 (owed 8), CoinReady tied 1: Coin sequence 101, 010, 001. Done with NotEnoughChange=0, Remaining=0; counts Q=2, D=2, N=2.
- INIT_Q=1, INIT_D=3, INIT_N=0; Cost=0, Paid=6: quarter dispensed, then Done with NotEnoughChange=1, Remaining=1; Q=0.
- Owed 5, CoinReady held 0 for 3 cycles with RefillValid, RefillQuarters=2 at Q=3: CoinValid high and Coin=101 for all 4 cycles. On the handshake Q=3 (saturated 3+2-1); InReady stays 0 until after Done.
- Reset asserted in OFFER: next cycle IDLE, InReady=1, CoinValid=0, all status 0, counts back to INIT_*.
